// File: rtl/pipeline_run_controller_pkg.sv
// Shared encodings for the pipeline run controller.
// Commands, states and the default drain length.
package pipeline_run_controller_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_STEP = 2'd2,
    CMD_STOP = 2'd3
  } run_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } run_state_t;

  localparam int unsigned RUN_DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipeline_run_controller_sat_cycle_counter.sv
// Enable-driven saturating counter with asynchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_cycle_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_count <= '0;
    end else if (i_en && (o_count != '1)) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_run_controller.sv
// Run/step/stop sequencer driving the pipeline total-stall; drains on HALT.
// Optional executed-cycle counter under MIPS_RUN_CYCLE_COUNTER_EN.
module pipeline_run_controller
  import pipeline_run_controller_pkg::*;
#(
  parameter int STEP_W       = 16,
  parameter int DRAIN_CYCLES = RUN_DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  input  logic [STEP_W-1:0] i_step_count,
  output logic              o_cmd_ready,
  input  logic              i_halt,
  output logic              o_total_stall,
  output logic              o_running,
  output logic              o_done,
  output logic [2:0]        o_state,
  output logic [CNT_W-1:0]  o_cycle_count
);

  localparam logic [2:0] DRAIN_LD = 3'(DRAIN_CYCLES);

  run_state_t        state, state_nx;
  logic [STEP_W-1:0] step_cnt, step_cnt_nx;
  logic [2:0]        drain_cnt, drain_cnt_nx;
  run_cmd_t          cmd;
  logic              accept;

  assign cmd    = run_cmd_t'(i_cmd);
  assign accept = i_cmd_valid && o_cmd_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      step_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      step_cnt  <= step_cnt_nx;
      drain_cnt <= drain_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    step_cnt_nx  = step_cnt;
    drain_cnt_nx = drain_cnt;
    case (state)
      ST_IDLE: begin
        if (accept && cmd == CMD_RUN) begin
          state_nx = ST_RUN;
        end else if (accept && cmd == CMD_STEP) begin
          state_nx    = ST_STEP;
          step_cnt_nx = (i_step_count == '0) ? STEP_W'(1)
                                             : i_step_count;
        end
      end
      ST_RUN: begin
        // HALT wins over a coincident STOP
        if (i_halt) begin
          state_nx     = ST_DRAIN;
          drain_cnt_nx = DRAIN_LD;
        end else if (accept && cmd == CMD_STOP) begin
          state_nx = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (i_halt) begin
          state_nx     = ST_DRAIN;
          drain_cnt_nx = DRAIN_LD;
        end else if (step_cnt == STEP_W'(1)) begin
          state_nx    = ST_IDLE;
          step_cnt_nx = '0;
        end else begin
          step_cnt_nx = step_cnt - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == 3'd1) begin
          state_nx     = ST_HALTED;
          drain_cnt_nx = '0;
        end else begin
          drain_cnt_nx = drain_cnt - 1'b1;
        end
      end
      ST_HALTED: state_nx = ST_HALTED;
      default: begin
        state_nx     = ST_IDLE;
        step_cnt_nx  = '0;
        drain_cnt_nx = '0;
      end
    endcase
  end

  always_comb begin
    o_total_stall = 1'b1;
    o_cmd_ready   = 1'b0;
    o_running     = 1'b0;
    o_done        = 1'b0;
    case (state)
      ST_IDLE: o_cmd_ready = 1'b1;
      ST_RUN: begin
        o_total_stall = 1'b0;
        o_cmd_ready   = 1'b1;
        o_running     = 1'b1;
      end
      ST_STEP, ST_DRAIN: begin
        o_total_stall = 1'b0;
        o_running     = 1'b1;
      end
      ST_HALTED: o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_state = state;

`ifdef MIPS_RUN_CYCLE_COUNTER_EN
  sat_cycle_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (!o_total_stall),
    .o_count (o_cycle_count)
  );
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Randomized + directed bench for pipeline_run_controller.
// Reference model tracks mode and remaining cycles in plain integers.
module tb_pipeline_run_controller;

  localparam int STEP_W = 16;
  localparam int DRAIN  = 3;
  localparam int CNT_W  = 6;
  localparam int CMAX   = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2;
  localparam int M_DRAIN = 3, M_HALT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd = 2'd0;
  logic [STEP_W-1:0] step_count = '0;
  logic              halt = 1'b0;
  logic              cmd_ready, total_stall, running, done;
  logic [2:0]        state;
  logic [CNT_W-1:0]  cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  int m_mode = M_IDLE;
  int m_rem  = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  pipeline_run_controller #(
    .STEP_W(STEP_W), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_cmd_valid  (cmd_valid),
    .i_cmd        (cmd),
    .i_step_count (step_count),
    .o_cmd_ready  (cmd_ready),
    .i_halt       (halt),
    .o_total_stall(total_stall),
    .o_running    (running),
    .o_done       (done),
    .o_state      (state),
    .o_cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int exp_count();
`ifdef MIPS_RUN_CYCLE_COUNTER_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic compare();
    bit adv;
    adv = (m_mode == M_RUN) || (m_mode == M_STEP) ||
          (m_mode == M_DRAIN);
    chk("stall", total_stall, !adv);
    chk("ready", cmd_ready, (m_mode == M_IDLE) || (m_mode == M_RUN));
    chk("running", running, adv);
    chk("done", done, m_mode == M_HALT);
    chk("state", state, m_mode);
    chk("count", cycle_count, exp_count());
  endtask

  // One clock of the reference: what the pipeline does at an edge.
  task automatic model_step(input bit v, input int c,
                            input int sc, input bit h);
    bit acc;
    acc = v && ((m_mode == M_IDLE) || (m_mode == M_RUN));
    if (m_mode inside {M_RUN, M_STEP, M_DRAIN} && m_cnt < CMAX)
      m_cnt++;
    case (m_mode)
      M_IDLE: begin
        if (acc && c == 1) m_mode = M_RUN;
        else if (acc && c == 2) begin
          m_mode = M_STEP;
          m_rem  = (sc == 0) ? 1 : sc;
        end
      end
      M_RUN: begin
        if (h) begin m_mode = M_DRAIN; m_rem = DRAIN; end
        else if (acc && c == 3) m_mode = M_IDLE;
      end
      M_STEP: begin
        if (h) begin m_mode = M_DRAIN; m_rem = DRAIN; end
        else begin
          m_rem--;
          if (m_rem == 0) m_mode = M_IDLE;
        end
      end
      M_DRAIN: begin
        m_rem--;
        if (m_rem == 0) m_mode = M_HALT;
      end
      default: ;
    endcase
  endtask

  task automatic tick(input bit v, input int c, input int sc,
                      input bit h);
    @(negedge clk);
    compare();
    cmd_valid  = v;
    cmd        = c[1:0];
    step_count = sc[STEP_W-1:0];
    halt       = h;
    @(posedge clk);
    model_step(v, c, sc, h);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    halt = 1'b0;
    #1;
    chk("rst_stall", total_stall, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state, 0);
    chk("rst_count", cycle_count, 0);
    m_mode = M_IDLE;
    m_rem  = 0;
    m_cnt  = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    idle(10);
    tick(1'b1, 2, 5, 1'b0);
    idle(8);
    tick(1'b1, 2, 0, 1'b0);
    idle(3);
    tick(1'b1, 1, 0, 1'b0);
    tick(1'b1, 1, 0, 1'b0);
    tick(1'b1, 2, 4, 1'b0);
    idle(4);
    tick(1'b1, 3, 0, 1'b0);
    idle(3);
    tick(1'b1, 1, 0, 1'b0);
    idle(2);
    tick(1'b1, 3, 0, 1'b1);
    idle(6);
    for (int i = 0; i < 4; i++) tick(1'b1, 1, 0, 1'b0);
    do_reset();
    tick(1'b0, 0, 0, 1'b1);
    tick(1'b1, 2, 3, 1'b0);
    tick(1'b0, 0, 0, 1'b0);
    tick(1'b0, 0, 0, 1'b0);
    tick(1'b0, 0, 0, 1'b1);
    tick(1'b0, 0, 0, 1'b0);
    do_reset();
    idle(2);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else tick($urandom_range(0, 2) != 0,
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 6)),
                $urandom_range(0, 39) == 0);
    end
    do_reset();
    tick(1'b1, 1, 0, 1'b0);
    idle(80);
    tick(1'b1, 3, 0, 1'b0);
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
